sdr_cmd_decoder: RTL

SDR_CMD_DECODER -- requirements
Module: sdr_cmd_decoder

---
 rtl/sdr_cmd_decoder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sdr_cmd_decoder.sv
// SDRAM command bus decoder: registered command report, init-sequence tracking and protocol checking.
// Define SDR_CMD_DEC_TIMING_CHK_EN to add the tRCD/tRP/tRFC checkers (error codes 3, 4, 8).
module sdr_cmd_decoder #(
    parameter int TRCD = 3,
    parameter int TRP  = 3,
    parameter int TRFC = 7
) (
    input  logic        sdram_clk,
    input  logic        sdram_resetn,
    input  logic        sdr_cs_n,
    input  logic        sdr_ras_n,
    input  logic        sdr_cas_n,
    input  logic        sdr_we_n,
    input  logic [1:0]  sdr_ba,
    input  logic [12:0] sdr_addr,
    output logic        cmd_valid,
    output logic [2:0]  cmd_code,
    output logic [1:0]  cmd_bank,
    output logic [3:0]  bank_open,
    output logic        init_done,
    output logic [12:0] mode_reg,
    output logic        err_valid,
    output logic [3:0]  err_code,
    output logic [7:0]  err_count
);

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0, CMD_ACT = 3'd1, CMD_RD  = 3'd2, CMD_WR  = 3'd3,
        CMD_PRE = 3'd4, CMD_REF = 3'd5, CMD_MRS = 3'd6, CMD_BST = 3'd7
    } cmd_t;

    typedef enum logic [2:0] {
        WAIT_PRE, WAIT_REF1, WAIT_REF2, WAIT_MRS, READY
    } init_state_t;

    init_state_t state, state_next;
    cmd_t        cmd;
    logic        is_rw;
    logic        is_active;
    logic [8:1]  viol;
    logic [3:0]  err_code_next;
    logic [3:0]  bank_open_next;
    logic [3:0]  ap_pending, ap_pending_next;

    always_comb begin
        cmd = CMD_NOP;
        if (!sdr_cs_n) begin
            case ({sdr_ras_n, sdr_cas_n, sdr_we_n})
                3'b011:  cmd = CMD_ACT;
                3'b101:  cmd = CMD_RD;
                3'b100:  cmd = CMD_WR;
                3'b010:  cmd = CMD_PRE;
                3'b001:  cmd = CMD_REF;
                3'b000:  cmd = CMD_MRS;
                3'b110:  cmd = CMD_BST;
                default: cmd = CMD_NOP;
            endcase
        end
    end

    assign is_rw     = (cmd == CMD_RD) || (cmd == CMD_WR);
    // BST is reported but, like NOP, never checked and never changes state.
    assign is_active = (cmd != CMD_NOP) && (cmd != CMD_BST);

`ifdef SDR_CMD_DEC_TIMING_CHK_EN
    logic [7:0] trcd_cnt [4];
    logic [7:0] trp_cnt  [4];
    logic [7:0] trfc_cnt;
    logic       trp_any;

    // Counters load N-1 so a command exactly N cycles later sees zero.
    always_ff @(posedge sdram_clk) begin
        if (!sdram_resetn) begin
            for (int i = 0; i < 4; i++) begin
                trcd_cnt[i] <= 8'd0;
                trp_cnt[i]  <= 8'd0;
            end
            trfc_cnt <= 8'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (cmd == CMD_ACT && sdr_ba == 2'(i))
                    trcd_cnt[i] <= 8'(TRCD - 1);
                else if (trcd_cnt[i] != 8'd0)
                    trcd_cnt[i] <= trcd_cnt[i] - 8'd1;
                if (cmd == CMD_PRE && (sdr_addr[10] || sdr_ba == 2'(i)))
                    trp_cnt[i] <= 8'(TRP - 1);
                else if (trp_cnt[i] != 8'd0)
                    trp_cnt[i] <= trp_cnt[i] - 8'd1;
            end
            if (cmd == CMD_REF)
                trfc_cnt <= 8'(TRFC - 1);
            else if (trfc_cnt != 8'd0)
                trfc_cnt <= trfc_cnt - 8'd1;
        end
    end

    assign trp_any = (trp_cnt[0] != 8'd0) || (trp_cnt[1] != 8'd0) ||
                     (trp_cnt[2] != 8'd0) || (trp_cnt[3] != 8'd0);
`endif

    always_ff @(posedge sdram_clk) begin
        if (!sdram_resetn) state <= WAIT_PRE;
        else               state <= state_next;
    end

    always_comb begin
        state_next = state;
        viol       = '0;
        viol[1]    = (cmd == CMD_ACT) && bank_open[sdr_ba];
        viol[2]    = is_rw && !bank_open[sdr_ba];
        viol[5]    = (cmd == CMD_REF) && (bank_open != 4'b0000);
        viol[6]    = (cmd == CMD_MRS) && (bank_open != 4'b0000);
`ifdef SDR_CMD_DEC_TIMING_CHK_EN
        viol[3]    = is_rw && (trcd_cnt[sdr_ba] != 8'd0);
        viol[4]    = ((cmd == CMD_ACT) && (trp_cnt[sdr_ba] != 8'd0)) ||
                     ((cmd == CMD_REF) && trp_any);
        viol[8]    = is_active && (trfc_cnt != 8'd0);
`endif
        if (is_active) begin
            case (state)
                WAIT_PRE:  if (cmd == CMD_PRE && sdr_addr[10]) state_next = WAIT_REF1;
                           else viol[7] = 1'b1;
                WAIT_REF1: if (cmd == CMD_REF) state_next = WAIT_REF2;
                           else viol[7] = 1'b1;
                WAIT_REF2: if (cmd == CMD_REF) state_next = WAIT_MRS;
                           else viol[7] = 1'b1;
                WAIT_MRS:  if (cmd == CMD_MRS) state_next = READY;
                           else viol[7] = 1'b1;
                default:   ;
            endcase
        end
        // Scan downward so the lowest-numbered violation wins.
        err_code_next = 4'd0;
        for (int i = 8; i >= 1; i--) begin
            if (viol[i]) err_code_next = 4'(i);
        end
    end

    // Auto-precharge closes the bank one cycle after the RD/WR is reported.
    always_comb begin
        bank_open_next  = bank_open & ~ap_pending;
        ap_pending_next = 4'b0000;
        case (cmd)
            CMD_ACT: bank_open_next[sdr_ba] = 1'b1;
            CMD_PRE: begin
                if (sdr_addr[10]) bank_open_next = 4'b0000;
                else              bank_open_next[sdr_ba] = 1'b0;
            end
            CMD_RD, CMD_WR: ap_pending_next[sdr_ba] = sdr_addr[10] && bank_open[sdr_ba];
            default: ;
        endcase
    end

    always_ff @(posedge sdram_clk) begin
        if (!sdram_resetn) begin
            cmd_valid  <= 1'b0;
            cmd_code   <= 3'd0;
            cmd_bank   <= 2'd0;
            bank_open  <= 4'b0000;
            ap_pending <= 4'b0000;
            init_done  <= 1'b0;
            mode_reg   <= 13'd0;
            err_valid  <= 1'b0;
            err_code   <= 4'd0;
            err_count  <= 8'd0;
        end else begin
            cmd_valid  <= (cmd != CMD_NOP);
            cmd_code   <= cmd;
            cmd_bank   <= (cmd != CMD_NOP) ? sdr_ba : 2'd0;
            bank_open  <= bank_open_next;
            ap_pending <= ap_pending_next;
            init_done  <= (state_next == READY);
            err_valid  <= (viol != '0);
            err_code   <= err_code_next;
            if (cmd == CMD_MRS)
                mode_reg <= sdr_addr;
            if (viol != '0 && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule
